ahb_rd_ecc_master: RTL and testbench
====================================

AHB_RD_ECC_MASTER -- requirements
Module: ahb_rd_ecc_master

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, read-data buffer entries (power of 2, >=2); CNT_W, default 16, width of the error counters.
REQ-002 SHALL have ports, clock and reset first:
- hclk  in  1  clock.
- hresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  read command request.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_addr  in  32  start byte address, word aligned.
- cmd_len  in  4  beats minus 1 (1..16 beats).
- hbusreq  out  1  bus request.
- hlock  out  1  tied 0.
- hgrant  in  1  bus grant.
- haddr  out  32  address.
- htrans  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  out  1  tied 0.
- hsize  out  3  tied 3'b010.
- hburst  out  3  tied INCR 3'b001.
- hwdata  out  64  tied 0.
- hrdata  in  32  SECDED codeword.
- hready  in  1  transfer done.
- hresp  in  2  00=OKAY, other=error.
- rd_valid, rd_ready  out/in  1  output stream handshake.
- rd_data  out  26  decoded data.
- rd_last  out  1  final beat of the command.
- rd_sec  out  1  single error corrected.
- rd_ded  out  1  double error, data uncorrected.
- rd_berr  out  1  hresp error on this beat.
- sec_cnt, ded_cnt  out  CNT_W  saturating error counters.

Function
REQ-003 SHALL run the FSM IDLE -> REQ -> ADDR -> DRAIN -> IDLE; cmd_ready=1 only in IDLE; on acceptance, latch addr/len and enter REQ.
REQ-004 In REQ, hbusreq SHALL be 1; the FSM SHALL move to ADDR when hgrant=1 and hready=1 are sampled.
REQ-005 In ADDR, the first beat and any beat after a break SHALL be NONSEQ, others SEQ; an address phase completes on a clock edge with hready=1; haddr then increments by 4.
REQ-006 When the next address is a 1KB boundary (haddr[9:0]==0), that beat SHALL be NONSEQ.
REQ-007 Flow control: a new address SHALL be issued only if FIFO free entries exceed outstanding data phases; otherwise htrans=BUSY holding haddr.
REQ-008 hbusreq SHALL drop in the cycle after the last address phase completes; the FSM then enters DRAIN until the last data phase completes, then IDLE.
REQ-009 If hgrant=0 is sampled mid-burst, SHALL drive IDLE, return to REQ, and resume at the pending address with NONSEQ; no beat is lost or duplicated.
REQ-010 Data capture: each data phase completing with hready=1 SHALL push one decoded entry {data,last,sec,ded,berr} into the FIFO on that edge.
REQ-011 Codeword positions 1..32 map to hrdata[0..31]. Parity sits at positions 1,2,4,8,16,32. Data bit 1 is at position 3, bits 2-4 at 5-7, bits 5-11 at 9-15, bits 12-26 at 17-31.
REQ-012 Decode: syndrome s[i] SHALL be the XOR of positions 1..31 whose index has bit i set; overall = XOR of all 32 bits.
REQ-013 Decode outcomes SHALL be:
- s=0, overall=0: clean.
- overall=1: flip position s (s=0 means position 32), sec=1.
- s!=0, overall=0: ded=1, data passed raw.
REQ-014 If hresp!=OKAY, SHALL push the beat with berr=1 and last=1, cancel the remaining addresses (htrans=IDLE), drop hbusreq, and go IDLE after the FIFO push.
REQ-015 rd_valid SHALL equal FIFO non-empty; pop on rd_valid&rd_ready; a simultaneous push and pop on a full FIFO SHALL not be possible (REQ-007 guarantees it).
REQ-016 sec_cnt/ded_cnt SHALL increment on each pushed sec/ded entry and saturate at all-ones.
REQ-017 First pushed data SHALL appear on rd_valid one cycle after capture when the FIFO is empty.

Reset
REQ-018 On hresetn=0, at any time including mid-burst: FSM=IDLE, hbusreq=0, htrans=IDLE, haddr=0, FIFO empty, rd_valid=0, rd_* =0, counters=0, cmd_ready=1 after release.

Verification
REQ-019 Command addr=0x100, len=3, hgrant=1, hready=1, clean words -> htrans NONSEQ,SEQ,SEQ,SEQ at 0x100..0x10C; 4 beats out, rd_last on the 4th.
REQ-020 Codeword of data 26'h5 with position 1 flipped -> rd_data=26'h5, rd_sec=1, sec_cnt=1.
REQ-021 Codeword with positions 1 and 2 flipped -> rd_ded=1, ded_cnt=1, rd_sec=0.
REQ-022 rd_ready=0, len=15 -> exactly 4 beats buffered, htrans=BUSY afterwards; release -> 16 beats in order, no loss.
REQ-023 addr=0x3F8, len=3 -> NONSEQ at 0x3F8, SEQ 0x3FC, NONSEQ 0x400, SEQ 0x404.
REQ-024 hresp=01 on beat 2 of 4 -> beat 2 out with rd_berr=1, rd_last=1; no further address phases; FSM IDLE.

Source files
------------

// File: rtl/ahb_rd_ecc_master.sv
// AHB-Lite read master: issues INCR read bursts, SECDED-decodes each returned word
// into a small FIFO and presents it as a valid/ready stream with error counters.
module ahb_rd_ecc_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [3:0]       cmd_len,
    output logic             hbusreq,
    output logic             hlock,
    input  logic             hgrant,
    output logic [31:0]      haddr,
    output logic [1:0]       htrans,
    output logic             hwrite,
    output logic [2:0]       hsize,
    output logic [2:0]       hburst,
    output logic [63:0]      hwdata,
    input  logic [31:0]      hrdata,
    input  logic             hready,
    input  logic [1:0]       hresp,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [25:0]      rd_data,
    output logic             rd_last,
    output logic             rd_sec,
    output logic             rd_ded,
    output logic             rd_berr,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DRAIN} state_t;
    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } trans_t;

    state_t      state, state_nxt;
    trans_t      trans;
    logic [31:0] addr_q;
    logic [3:0]  beats_left;
    logic        need_nonseq;
    logic        dp_valid;
    logic        dp_last;
    logic        err;
    logic        push;
    logic        pop;
    logic        addr_go;
    logic        can_issue;

    logic [29:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count, free;
    logic [29:0] head;

    logic [4:0]  syn;
    logic        overall;
    logic [31:0] flip;
    logic [31:0] cw;
    logic [25:0] dec_data;
    logic        dec_sec;
    logic        dec_ded;

    assign hlock  = 1'b0;
    assign hwrite = 1'b0;
    assign hsize  = 3'b010;
    assign hburst = 3'b001;
    assign hwdata = '0;
    assign haddr  = addr_q;
    assign htrans = trans;

    assign err       = dp_valid && (hresp != 2'b00);
    assign push      = dp_valid && hready;
    assign count     = wr_ptr - rd_ptr;
    assign free      = DEPTH_V - count;
    // The FIFO must keep room for every data phase already in flight plus the new one.
    assign can_issue = free > (AW+1)'(dp_valid);
    assign addr_go   = hready && (trans == TR_NONSEQ || trans == TR_SEQ);

    always_comb begin
        trans = TR_IDLE;
        if (state == S_ADDR && !err) begin
            if (can_issue)
                trans = (need_nonseq || addr_q[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
            else if (!need_nonseq)
                trans = TR_BUSY;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        hbusreq   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                hbusreq = 1'b1;
                if (err && hready)
                    state_nxt = S_IDLE;
                else if (hgrant && hready)
                    state_nxt = S_ADDR;
            end
            S_ADDR: begin
                hbusreq = 1'b1;
                if (hready) begin
                    if (err)
                        state_nxt = S_IDLE;
                    else if (addr_go && beats_left == 4'd0)
                        state_nxt = S_DRAIN;
                    else if (!hgrant)
                        state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (!dp_valid || hready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q      <= '0;
            beats_left  <= '0;
            need_nonseq <= 1'b0;
            dp_valid    <= 1'b0;
            dp_last     <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                addr_q      <= cmd_addr;
                beats_left  <= cmd_len;
                need_nonseq <= 1'b1;
            end
            if (addr_go) begin
                addr_q      <= addr_q + 32'd4;
                need_nonseq <= 1'b0;
                dp_last     <= (beats_left == 4'd0);
                if (beats_left != 4'd0)
                    beats_left <= beats_left - 4'd1;
            end
            // Losing the grant forces the resumed transfer to restart as NONSEQ.
            if (state == S_ADDR && hready && !hgrant)
                need_nonseq <= 1'b1;
            if (addr_go)
                dp_valid <= 1'b1;
            else if (hready)
                dp_valid <= 1'b0;
        end
    end

    // SECDED: codeword position p lives in hrdata[p-1]; masks select positions with syndrome bit i set.
    always_comb begin
        syn[0]  = ^(hrdata & 32'h5555_5555);
        syn[1]  = ^(hrdata & 32'h6666_6666);
        syn[2]  = ^(hrdata & 32'h7878_7878);
        syn[3]  = ^(hrdata & 32'h7F80_7F80);
        syn[4]  = ^(hrdata & 32'h7FFF_8000);
        overall = ^hrdata;
        flip    = '0;
        if (overall)
            flip = (syn == 5'd0) ? 32'h8000_0000 : (32'd1 << (syn - 5'd1));
        cw       = hrdata ^ flip;
        dec_sec  = overall;
        dec_ded  = !overall && (syn != 5'd0);
        dec_data = {cw[30:16], cw[14:8], cw[6:4], cw[2]};
    end

    always_ff @(posedge hclk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {dec_data, dp_last || err, dec_sec, dec_ded, err};
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && dec_sec && sec_cnt != '1)
                sec_cnt <= sec_cnt + CNT_W'(1);
            if (push && dec_ded && ded_cnt != '1)
                ded_cnt <= ded_cnt + CNT_W'(1);
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? head[29:4] : '0;
    assign rd_last  = rd_valid && head[3];
    assign rd_sec   = rd_valid && head[2];
    assign rd_ded   = rd_valid && head[1];
    assign rd_berr  = rd_valid && head[0];

endmodule

// File: tb/tb_ahb_rd_ecc_master.sv
// Scoreboard bench for ahb_rd_ecc_master: a small AHB slave model feeds SECDED words,
// expected beats are queued at issue time and checked as the stream drains.
module tb_ahb_rd_ecc_master;
    logic        hclk = 1'b0;
    logic        hresetn, cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        hbusreq, hlock, hgrant, hwrite, hready;
    logic [31:0] haddr, hrdata;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, hburst;
    logic [63:0] hwdata;
    logic        rd_valid, rd_ready, rd_last, rd_sec, rd_ded, rd_berr;
    logic [25:0] rd_data;
    logic [15:0] sec_cnt, ded_cnt;

    int errors = 0;
    int checks = 0;
    logic [29:0] expq[$];
    logic [33:0] trace[$];

    logic        a_v, a_hr, dph_v, stall_mode;
    logic [31:0] a_addr, dph_addr;
    logic [1:0]  a_tr;
    logic        inj_en, err_en;
    logic [31:0] inj_addr, inj_word, err_addr;
    logic [29:0] e;

    logic [31:0] vec_word [5] = '{32'h0000_002D, 32'h0000_002C, 32'h0000_002E,
                                  32'h0000_0029, 32'h8000_002D};
    logic [1:0]  vec_sd   [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b10};

    always #5 hclk = ~hclk;

    ahb_rd_ecc_master #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .hbusreq(hbusreq), .hlock(hlock), .hgrant(hgrant), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .rd_sec(rd_sec), .rd_ded(rd_ded), .rd_berr(rd_berr),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    function automatic logic [31:0] enc(input logic [25:0] d);
        logic [31:0] c;
        int k;
        logic par;
        c = '0;
        k = 0;
        for (int p = 1; p <= 31; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            par = 1'b0;
            for (int p = 1; p <= 31; p++)
                if ((p & (1 << i)) != 0) par ^= c[p-1];
            c[(1 << i) - 1] = par;
        end
        c[31] = ^c[30:0];
        return c;
    endfunction

    always_comb begin
        hrdata = '0;
        hresp  = 2'b00;
        if (dph_v) begin
            hrdata = (inj_en && dph_addr == inj_addr) ? inj_word : enc(dph_addr[27:2]);
            if (err_en && dph_addr == err_addr) hresp = 2'b01;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Bus monitor and slave: address phases are sampled mid-cycle, committed at the edge.
    initial begin
        hready = 1'b1;
        dph_v = 1'b0;
        dph_addr = '0;
        forever begin
            @(negedge hclk);
            a_hr = hready;
            a_v = hready && htrans[1];
            a_addr = haddr;
            a_tr = htrans;
            @(posedge hclk);
            if (hresetn && a_v) trace.push_back({a_tr, a_addr});
            #1;
            if (!hresetn) dph_v = 1'b0;
            else if (a_hr) begin
                dph_v = a_v;
                dph_addr = a_addr;
            end
            hready = stall_mode ? ~hready : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge hclk);
            if (hresetn && rd_valid && rd_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", rd_data);
                end else begin
                    e = expq.pop_front();
                    check("rd_beat", {rd_data, rd_last, rd_sec, rd_ded, rd_berr}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] l);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(cmd_ready && expq.size() == 0 && !rd_valid) && n < budget) begin
            tick();
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    task automatic expect_burst(input logic [31:0] a, input int beats);
        logic [31:0] ad;
        for (int i = 0; i < beats; i++) begin
            ad = a + 32'(4 * i);
            expq.push_back({ad[27:2], i == beats - 1, 3'b000});
        end
    endtask

    task automatic check_trace(input string name, input logic [31:0] a, input int n,
                               input logic [15:0] ns_mask);
        check({name, "_count"}, trace.size(), n);
        for (int i = 0; i < n && i < trace.size(); i++) begin
            check({name, "_addr"}, trace[i][31:0], a + 32'(4 * i));
            check({name, "_trans"}, trace[i][33:32], ns_mask[i] ? 2'b10 : 2'b11);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        hgrant = 1'b1; rd_ready = 1'b1; stall_mode = 1'b0;
        inj_en = 1'b0; inj_addr = '0; inj_word = '0; err_en = 1'b0; err_addr = '0;
        repeat (3) tick();
        hresetn = 1'b1;
        tick();
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_hbusreq", hbusreq, 1'b0);
        check("reset_htrans", htrans, 2'b00);
        check("reset_haddr", haddr, 32'h0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_counters", {sec_cnt, ded_cnt}, 32'h0);

        // Basic 4-beat burst
        trace.delete();
        expect_burst(32'h100, 4);
        issue(32'h100, 4'd3);
        wait_done("t1_done", 200);
        check_trace("t1", 32'h100, 4, 16'h0001);

        // Single-beat decode table: clean, pos1, pos1+2, pos3, pos32
        inj_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inj_addr = 32'h200 + 32'(4 * i);
            inj_word = vec_word[i];
            expq.push_back({26'h5, 1'b1, vec_sd[i], 1'b0});
            issue(inj_addr, 4'd0);
            wait_done("ecc_done", 100);
        end
        inj_en = 1'b0;
        check("sec_cnt", sec_cnt, 16'd3);
        check("ded_cnt", ded_cnt, 16'd1);

        // Backpressure: FIFO fills to depth, then BUSY
        rd_ready = 1'b0;
        trace.delete();
        expect_burst(32'h1000, 16);
        issue(32'h1000, 4'd15);
        repeat (20) tick();
        check("bp_issued", trace.size(), 4);
        check("bp_htrans_busy", htrans, 2'b01);
        check("bp_haddr_held", haddr, 32'h1010);
        check("bp_hbusreq", hbusreq, 1'b1);
        check("bp_rd_valid", rd_valid, 1'b1);
        rd_ready = 1'b1;
        wait_done("bp_done", 400);
        check_trace("bp", 32'h1000, 16, 16'h0001);

        // 1KB boundary crossing
        trace.delete();
        expect_burst(32'h3F8, 4);
        issue(32'h3F8, 4'd3);
        wait_done("kb_done", 200);
        check_trace("kb", 32'h3F8, 4, 16'h0005);

        // Error response on beat 2 of 4
        err_en = 1'b1;
        err_addr = 32'h2004;
        trace.delete();
        expq.push_back({26'h800, 4'b0000});
        expq.push_back({26'h801, 4'b1001});
        issue(32'h2000, 4'd3);
        wait_done("err_done", 200);
        repeat (3) tick();
        check_trace("err", 32'h2000, 2, 16'h0001);
        check("err_idle", {cmd_ready, hbusreq, htrans}, 4'b1000);
        err_en = 1'b0;

        // Grant withdrawn mid-burst, resumes with NONSEQ at the pending address
        trace.delete();
        expect_burst(32'h3000, 6);
        issue(32'h3000, 4'd5);
        for (int n = 0; n < 100 && trace.size() < 2; n++) tick();
        hgrant = 1'b0;
        tick();
        tick();
        check("gl_hbusreq", hbusreq, 1'b1);
        check("gl_htrans_idle", htrans, 2'b00);
        tick();
        hgrant = 1'b1;
        wait_done("gl_done", 200);
        check_trace("gl", 32'h3000, 6, 16'h0009);

        // Wait states on every other cycle
        stall_mode = 1'b1;
        trace.delete();
        expect_burst(32'h500, 4);
        issue(32'h500, 4'd3);
        wait_done("ws_done", 300);
        check_trace("ws", 32'h500, 4, 16'h0001);
        stall_mode = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a stalled burst
        rd_ready = 1'b0;
        issue(32'h4000, 4'd15);
        repeat (8) tick();
        hresetn = 1'b0;
        expq.delete();
        tick();
        check("mr_rd_valid", rd_valid, 1'b0);
        check("mr_bus", {hbusreq, htrans}, 3'b000);
        check("mr_haddr", haddr, 32'h0);
        check("mr_counters", {sec_cnt, ded_cnt}, 32'h0);
        tick();
        hresetn = 1'b1;
        rd_ready = 1'b1;
        tick();
        check("mr_cmd_ready", cmd_ready, 1'b1);

        // Recovery after reset
        trace.delete();
        expect_burst(32'h40, 2);
        issue(32'h40, 4'd1);
        wait_done("rec_done", 200);
        check_trace("rec", 32'h40, 2, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
